sample_sequencer: RTL and testbench

SAMPLE_SEQUENCER -- requirements
Module: sample_sequencer

---
 rtl/audio_seq_pkg.sv | 17 +
 rtl/sat_counter8.sv | 23 ++
 rtl/sample_sequencer.sv | 171 +++++++++++++++++
 tb/tb_sample_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_seq_pkg.sv
// Shared state encoding, channel codes and parameter defaults for the audio sample sequencer.
package audio_seq_pkg;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_PLAY  = 3'd4
  } state_t;

  localparam logic [1:0] CH_BYPASS = 2'd0;

  localparam int HOLD_CYCLES_DEF = 4;
  localparam int TIMEOUT_DEF     = 255;

endpackage

// File: rtl/sat_counter8.sv
// 8-bit event counter that sticks at 255; one cycle from inc to updated count, no backpressure.
module sat_counter8 (
  input  logic       mclk,
  input  logic       rst,
  input  logic       inc,
  output logic [7:0] cnt
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != 8'hFF)) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/sample_sequencer.sv
// Routes each ADC sample straight to the DAC or through an effect processor with a timeout fallback.
// Bypass plays one cycle after the in_en edge; samples arriving while busy are dropped and counted.
module sample_sequencer
  import audio_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int TIMEOUT     = TIMEOUT_DEF
) (
  input  logic        mclk,
  input  logic        rst,
  input  logic        init_done,
  input  logic [15:0] in_data,
  input  logic        in_en,
  input  logic [1:0]  channel,
  output logic        proc_start,
  output logic [1:0]  proc_sel,
  output logic [15:0] proc_data,
  input  logic        proc_done,
  input  logic [15:0] proc_result,
  output logic [15:0] out_data,
  output logic        out_valid,
  output logic        busy,
  output logic [7:0]  overrun_cnt,
  output logic [7:0]  timeout_cnt
);

  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);
  localparam logic [7:0]  HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_t      state_q, state_d;
  logic        in_en_prev_q, in_en_prev_d;
  logic [15:0] smp_q, smp_d;
  logic [15:0] tmo_q, tmo_d;
  logic [7:0]  hold_q, hold_d;
  logic [15:0] out_data_q, out_data_d;
  logic [15:0] proc_data_q, proc_data_d;
  logic [1:0]  proc_sel_q, proc_sel_d;
  logic        out_valid_q, out_valid_d;
  logic        proc_start_q, proc_start_d;
  logic        busy_q, busy_d;
  logic        ovr_inc, tmo_inc;
  logic        in_evt;

  assign in_evt = in_en && !in_en_prev_q;

  always_comb begin
    state_d      = state_q;
    in_en_prev_d = in_en;
    smp_d        = smp_q;
    tmo_d        = tmo_q;
    hold_d       = hold_q;
    out_data_d   = out_data_q;
    proc_data_d  = proc_data_q;
    proc_sel_d   = proc_sel_q;
    out_valid_d  = out_valid_q;
    proc_start_d = 1'b0;
    ovr_inc      = 1'b0;
    tmo_inc      = 1'b0;

    // Losing codec configuration aborts whatever is in flight without touching counters.
    if (!init_done) begin
      state_d     = ST_INIT;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_INIT: state_d = ST_IDLE;
        ST_IDLE: begin
          if (in_evt) begin
            smp_d = in_data;
            if (channel == CH_BYPASS) begin
              out_data_d  = in_data;
              out_valid_d = 1'b1;
              hold_d      = '0;
              state_d     = ST_PLAY;
            end else begin
              proc_start_d = 1'b1;
              proc_sel_d   = channel;
              proc_data_d  = in_data;
              state_d      = ST_START;
            end
          end
        end
        ST_START: begin
          tmo_d   = '0;
          state_d = ST_WAIT;
        end
        ST_WAIT: begin
          // A completion on the last allowed cycle still beats the timeout.
          if (proc_done) begin
            out_data_d  = proc_result;
            out_valid_d = 1'b1;
            hold_d      = '0;
            state_d     = ST_PLAY;
          end else if (tmo_q == TMO_LAST) begin
            out_data_d  = smp_q;
            out_valid_d = 1'b1;
            tmo_inc     = 1'b1;
            hold_d      = '0;
            state_d     = ST_PLAY;
          end else begin
            tmo_d = tmo_q + 16'd1;
          end
        end
        ST_PLAY: begin
          if (hold_q == HOLD_LAST) begin
            out_valid_d = 1'b0;
            state_d     = ST_IDLE;
          end else begin
            hold_d = hold_q + 8'd1;
          end
        end
        default: state_d = ST_INIT;
      endcase

      if (in_evt && (state_q == ST_START || state_q == ST_WAIT || state_q == ST_PLAY))
        ovr_inc = 1'b1;
    end

    busy_d = (state_d == ST_START) || (state_d == ST_WAIT) || (state_d == ST_PLAY);
  end

  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_INIT;
      in_en_prev_q <= 1'b0;
      smp_q        <= '0;
      tmo_q        <= '0;
      hold_q       <= '0;
      out_data_q   <= '0;
      proc_data_q  <= '0;
      proc_sel_q   <= '0;
      out_valid_q  <= 1'b0;
      proc_start_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_en_prev_q <= in_en_prev_d;
      smp_q        <= smp_d;
      tmo_q        <= tmo_d;
      hold_q       <= hold_d;
      out_data_q   <= out_data_d;
      proc_data_q  <= proc_data_d;
      proc_sel_q   <= proc_sel_d;
      out_valid_q  <= out_valid_d;
      proc_start_q <= proc_start_d;
      busy_q       <= busy_d;
    end
  end

  sat_counter8 u_ovr_cnt (
    .mclk (mclk),
    .rst  (rst),
    .inc  (ovr_inc),
    .cnt  (overrun_cnt)
  );

  sat_counter8 u_tmo_cnt (
    .mclk (mclk),
    .rst  (rst),
    .inc  (tmo_inc),
    .cnt  (timeout_cnt)
  );

  assign proc_start = proc_start_q;
  assign proc_sel   = proc_sel_q;
  assign proc_data  = proc_data_q;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_sample_sequencer.sv
// Randomized transaction bench: predicts each sample's cycle timeline and counter totals from its parameters.
module tb_sample_sequencer;

  localparam int HOLD = 4;
  localparam int TMO  = 255;

  logic        mclk = 1'b0;
  logic        rst;
  logic        init_done;
  logic [15:0] in_data;
  logic        in_en;
  logic [1:0]  channel;
  logic        proc_start;
  logic [1:0]  proc_sel;
  logic [15:0] proc_data;
  logic        proc_done;
  logic [15:0] proc_result;
  logic [15:0] out_data;
  logic        out_valid;
  logic        busy;
  logic [7:0]  overrun_cnt;
  logic [7:0]  timeout_cnt;

  int n_chk = 0;
  int n_bad = 0;
  int ovr_exp = 0;
  int tmo_exp = 0;

  sample_sequencer #(.HOLD_CYCLES(HOLD), .TIMEOUT(TMO)) dut (
    .mclk        (mclk),
    .rst         (rst),
    .init_done   (init_done),
    .in_data     (in_data),
    .in_en       (in_en),
    .channel     (channel),
    .proc_start  (proc_start),
    .proc_sel    (proc_sel),
    .proc_data   (proc_data),
    .proc_done   (proc_done),
    .proc_result (proc_result),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .busy        (busy),
    .overrun_cnt (overrun_cnt),
    .timeout_cnt (timeout_cnt)
  );

  always #5 mclk = ~mclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_ovr"}, 32'(overrun_cnt), 32'(ovr_exp));
    chk({tag, "_tmo"}, 32'(timeout_cnt), 32'(tmo_exp));
  endtask

  // One sample from its rising in_en edge (offset 0) until the sequencer is idle again.
  // done_off: offset at which proc_done pulses (0 = never); ovmode: 0 none, 1 sparse, 2 dense, 3 one edge at offset 5.
  task automatic run_txn(input logic [1:0] ch, input logic [15:0] d, input int done_off,
                         input logic [15:0] res, input int ovmode);
    bit          ov [0:299];
    int          play_start, play_end, last, nov;
    logic [15:0] expo;
    bit          processed, take, in_play;
    processed = (ch != 2'd0);
    in_en = 1'b0;
    proc_done = 1'b0;
    step();

    if (!processed) begin
      play_start = 1;
      expo = d;
    end else if (done_off >= 2 && done_off <= TMO + 1) begin
      play_start = done_off + 1;
      expo = res;
    end else begin
      play_start = TMO + 2;
      expo = d;
      tmo_exp = sat(tmo_exp + 1);
    end
    play_end = play_start + HOLD - 1;

    for (int o = 0; o < 300; o++) ov[o] = 1'b0;
    last = 0;
    nov = 0;
    for (int o = 2; o <= play_end; o++) begin
      take = (ovmode == 2) || (ovmode == 1 && $urandom_range(0, 15) == 0) || (ovmode == 3 && o == 5);
      if (take && o >= last + 2) begin
        ov[o] = 1'b1;
        last = o;
        nov++;
      end
    end
    ovr_exp = sat(ovr_exp + nov);

    in_data = d;
    channel = ch;
    in_en = 1'b1;
    step();

    for (int o = 1; o <= play_end + 1; o++) begin
      in_play = (o >= play_start) && (o <= play_end);
      chk("out_valid", 32'(out_valid), 32'(in_play));
      chk("proc_start", 32'(proc_start), 32'(processed && o == 1));
      chk("busy", 32'(busy), 32'(o <= play_end));
      if (in_play) chk("out_data", 32'(out_data), 32'(expo));
      if (processed && o < play_start) begin
        chk("proc_sel", 32'(proc_sel), 32'(ch));
        chk("proc_data", 32'(proc_data), 32'(d));
      end
      in_en = ov[o];
      in_data = 16'($urandom);
      channel = 2'($urandom);
      // Stray completions during START or PLAY must be ignored.
      proc_done = (o == done_off) ||
                  ((o == 1 || o >= play_start) && $urandom_range(0, 3) == 0);
      proc_result = (o == done_off) ? res : 16'($urandom);
      step();
    end
    proc_done = 1'b0;
    in_en = 1'b0;
    chk_counters("txn");
  endtask

  initial begin
    int doff, r;
    logic [1:0] ch;

    rst = 1'b0;
    init_done = 1'b0;
    in_data = '0;
    in_en = 1'b0;
    channel = '0;
    proc_done = 1'b0;
    proc_result = '0;

    step();
    step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_proc_start", 32'(proc_start), 32'd0);
    chk_counters("rst");

    rst = 1'b1;
    step();
    step();
    // Edges while waiting for the codec are neither played nor counted.
    in_data = 16'h7777;
    in_en = 1'b1;
    step();
    in_en = 1'b0;
    step();
    chk("init_no_play", 32'(out_valid), 32'd0);
    chk("init_busy", 32'(busy), 32'd0);
    chk_counters("init");
    init_done = 1'b1;
    step();

    run_txn(2'd0, 16'h1234, 0, 16'h0000, 0);
    run_txn(2'd2, 16'h0F0F, 11, 16'hA5A5, 0);
    run_txn(2'd1, 16'h3C3C, 0, 16'h9999, 0);
    run_txn(2'd1, 16'h4D4D, TMO + 1, 16'h5A5A, 0);
    run_txn(2'd3, 16'h2468, 20, 16'h1357, 3);

    for (int t = 0; t < 30; t++) begin
      ch = 2'($urandom_range(0, 3));
      r = $urandom_range(0, 9);
      case (r)
        6:       doff = TMO + 1;
        7:       doff = 0;
        8:       doff = TMO + 2;
        9:       doff = $urandom_range(2, TMO + 1);
        default: doff = $urandom_range(2, 15);
      endcase
      run_txn(ch, 16'($urandom), doff, 16'($urandom), $urandom_range(0, 1));
    end

    for (int k = 0; k < 3; k++) run_txn(2'd1, 16'($urandom), 0, 16'h0, 2);
    chk("ovr_saturated", 32'(overrun_cnt), 32'd255);

    // Codec drop in the middle of PLAY.
    in_en = 1'b0;
    step();
    in_data = 16'hC0DE;
    channel = 2'd0;
    in_en = 1'b1;
    step();
    chk("abort_play_vld", 32'(out_valid), 32'd1);
    in_en = 1'b0;
    step();
    init_done = 1'b0;
    step();
    chk("abort_vld", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_out_data", 32'(out_data), 32'hC0DE);
    chk_counters("abort");
    in_data = 16'h1111;
    in_en = 1'b1;
    step();
    in_en = 1'b0;
    step();
    chk("abort_init_vld", 32'(out_valid), 32'd0);
    chk_counters("abort_init");
    init_done = 1'b1;
    step();
    run_txn(2'd3, 16'h6543, 7, 16'h0BAD, 0);

    // Asynchronous reset in the middle of WAIT.
    in_en = 1'b0;
    step();
    in_data = 16'hBEEF;
    channel = 2'd2;
    in_en = 1'b1;
    step();
    in_en = 1'b0;
    step();
    step();
    chk("wait_busy", 32'(busy), 32'd1);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_proc_sel", 32'(proc_sel), 32'd0);
    chk("arst_proc_data", 32'(proc_data), 32'd0);
    chk("arst_out_data", 32'(out_data), 32'd0);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    ovr_exp = 0;
    tmo_exp = 0;
    chk_counters("arst");
    step();
    rst = 1'b1;
    step();
    run_txn(2'd0, 16'hFACE, 0, 16'h0, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
